// File: rtl/apple1_pkg.sv
// apple1_pkg
//   Definitions shared by the PS/2 keyboard front end of the Apple-1 core:
//   - PS/2 set-2 scancode constants used by the decoder
//   - the serial receiver state encoding
//   - a frame validity helper (odd parity over data+parity, stop bit high)
package apple1_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;

  // Modifier and special keys
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_F1     = 8'h05;
  localparam logic [7:0] SC_F12    = 8'h07;

  // Receiver states: start bit is consumed in IDLE, so DATA begins at bit 0
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // A frame is accepted only with odd parity across data+parity and a high stop bit
  function automatic logic frame_ok(input logic [7:0] data,
                                    input logic       parity,
                                    input logic       stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// ps2_scancode_to_ascii
//   Combinational translation of a PS/2 set-2 make code into 7-bit ASCII for
//   the Apple-1 (uppercase-only character set).
// Ports:
//   scancode [7:0] in   make code (prefix bytes never reach here as characters)
//   shift          in   either shift key held
//   ctrl           in   ctrl key held
//   ext            in   code was preceded by E0
//   ascii    [6:0] out  translated character (0 when not valid)
//   valid          out  scancode maps to a character
module ps2_scancode_to_ascii
  import apple1_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       ctrl,
  input  logic       ext,
  output logic [6:0] ascii,
  output logic       valid
);

  logic [6:0] base_ascii;
  logic       is_letter;

  always_comb begin
    base_ascii = 7'h00;
    valid      = 1'b0;
    is_letter  = 1'b0;

    if (ext) begin
      // Keypad Enter is the only extended key that types a character
      if (scancode == SC_ENTER) begin
        base_ascii = 7'h0D;
        valid      = 1'b1;
      end
    end else begin
      valid = 1'b1;
      case (scancode)
        // Letters: always uppercase, shift has no effect
        8'h1C: begin base_ascii = 7'h41; is_letter = 1'b1; end // A
        8'h32: begin base_ascii = 7'h42; is_letter = 1'b1; end // B
        8'h21: begin base_ascii = 7'h43; is_letter = 1'b1; end // C
        8'h23: begin base_ascii = 7'h44; is_letter = 1'b1; end // D
        8'h24: begin base_ascii = 7'h45; is_letter = 1'b1; end // E
        8'h2B: begin base_ascii = 7'h46; is_letter = 1'b1; end // F
        8'h34: begin base_ascii = 7'h47; is_letter = 1'b1; end // G
        8'h33: begin base_ascii = 7'h48; is_letter = 1'b1; end // H
        8'h43: begin base_ascii = 7'h49; is_letter = 1'b1; end // I
        8'h3B: begin base_ascii = 7'h4A; is_letter = 1'b1; end // J
        8'h42: begin base_ascii = 7'h4B; is_letter = 1'b1; end // K
        8'h4B: begin base_ascii = 7'h4C; is_letter = 1'b1; end // L
        8'h3A: begin base_ascii = 7'h4D; is_letter = 1'b1; end // M
        8'h31: begin base_ascii = 7'h4E; is_letter = 1'b1; end // N
        8'h44: begin base_ascii = 7'h4F; is_letter = 1'b1; end // O
        8'h4D: begin base_ascii = 7'h50; is_letter = 1'b1; end // P
        8'h15: begin base_ascii = 7'h51; is_letter = 1'b1; end // Q
        8'h2D: begin base_ascii = 7'h52; is_letter = 1'b1; end // R
        8'h1B: begin base_ascii = 7'h53; is_letter = 1'b1; end // S
        8'h2C: begin base_ascii = 7'h54; is_letter = 1'b1; end // T
        8'h3C: begin base_ascii = 7'h55; is_letter = 1'b1; end // U
        8'h2A: begin base_ascii = 7'h56; is_letter = 1'b1; end // V
        8'h1D: begin base_ascii = 7'h57; is_letter = 1'b1; end // W
        8'h22: begin base_ascii = 7'h58; is_letter = 1'b1; end // X
        8'h35: begin base_ascii = 7'h59; is_letter = 1'b1; end // Y
        8'h1A: begin base_ascii = 7'h5A; is_letter = 1'b1; end // Z

        // Digit row, with US shifted symbols
        8'h45: base_ascii = shift ? 7'h29 : 7'h30; // 0 )
        8'h16: base_ascii = shift ? 7'h21 : 7'h31; // 1 !
        8'h1E: base_ascii = shift ? 7'h40 : 7'h32; // 2 @
        8'h26: base_ascii = shift ? 7'h23 : 7'h33; // 3 #
        8'h25: base_ascii = shift ? 7'h24 : 7'h34; // 4 $
        8'h2E: base_ascii = shift ? 7'h25 : 7'h35; // 5 %
        8'h36: base_ascii = shift ? 7'h5E : 7'h36; // 6 ^
        8'h3D: base_ascii = shift ? 7'h26 : 7'h37; // 7 &
        8'h3E: base_ascii = shift ? 7'h2A : 7'h38; // 8 *
        8'h46: base_ascii = shift ? 7'h28 : 7'h39; // 9 (

        // Punctuation; shifted forms limited to the uppercase-only set
        8'h4E: base_ascii = shift ? 7'h5F : 7'h2D; // - _
        8'h55: base_ascii = shift ? 7'h2B : 7'h3D; // = +
        8'h4C: base_ascii = shift ? 7'h3A : 7'h3B; // ; :
        8'h52: base_ascii = shift ? 7'h22 : 7'h27; // ' "
        8'h41: base_ascii = shift ? 7'h3C : 7'h2C; // , <
        8'h49: base_ascii = shift ? 7'h3E : 7'h2E; // . >
        8'h4A: base_ascii = shift ? 7'h3F : 7'h2F; // / ?
        8'h54: base_ascii = 7'h5B;                 // [
        8'h5B: base_ascii = 7'h5D;                 // ]
        8'h5D: base_ascii = 7'h5C;                 // backslash

        // Control keys
        8'h29: base_ascii = 7'h20;                 // space
        8'h5A: base_ascii = 7'h0D;                 // Enter
        8'h66: base_ascii = 7'h5F;                 // Backspace shows as underscore (Apple-1 rubout)
        8'h76: base_ascii = 7'h1B;                 // Esc

        default: valid = 1'b0;
      endcase
    end
  end

  // Ctrl folds a letter into the 0x01-0x1A control range
  assign ascii = (ctrl && is_letter) ? (base_ascii & 7'h1F) : base_ascii;

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard
//   PS/2 keyboard receiver and set-2 decoder for the Apple-1 PIA keyboard port.
//   Synchronizes and debounces the PS/2 clock, deserializes 11-bit frames on the
//   filtered falling edge, validates parity/stop, tracks prefix and modifier
//   state, and latches translated characters with a ready/ack handshake.
// Parameters:
//   FILTER_LEN      cycles ps2_clk must hold a new level before the filtered clock follows
//   TIMEOUT_CYCLES  idle cycles outside IDLE before a partial frame is abandoned
// Ports:
//   clk14           in   system clock (14.31818 MHz)
//   rst_n           in   asynchronous active-low reset
//   ps2_clk         in   PS/2 clock (asynchronous)
//   ps2_data        in   PS/2 data  (asynchronous)
//   key_ascii [6:0] out  last decoded character
//   key_ready       out  character available (PIA KBD strobe)
//   key_ack         in   PIA data register read; clears key_ready
//   reset_key       out  high while F12 is held
//   cls_key         out  high while F1 is held
//   frame_err       out  one-cycle pulse per discarded frame
module ps2_keyboard
  import apple1_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14318
) (
  input  logic       clk14,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] key_ascii,
  output logic       key_ready,
  input  logic       key_ack,
  output logic       reset_key,
  output logic       cls_key,
  output logic       frame_err
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers (idle level of the PS/2 lines is high)
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       ps2_clk_s;
  logic       ps2_data_s;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign ps2_clk_s  = clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];

  // ---------------------------------------------------------------------------
  // Clock glitch filter: the counter runs only while the synchronized clock
  // disagrees with the filtered one; any agreement restarts it.
  // ---------------------------------------------------------------------------
  logic              clk_filt_q, clk_filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              fall_edge;

  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    fall_edge  = 1'b0;
    if (ps2_clk_s != clk_filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        clk_filt_d = ps2_clk_s;
        fall_edge  = ~ps2_clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             scan_valid_q, scan_valid_d;
  logic [7:0]       scan_code_q, scan_code_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    tmo_d        = tmo_q;
    scan_valid_d = 1'b0;
    scan_code_d  = scan_code_q;
    frame_err_d  = 1'b0;

    // Watchdog: only armed mid-frame, restarted by every falling edge
    if (state_q == IDLE || fall_edge) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (fall_edge) begin
      case (state_q)
        IDLE: begin
          if (!ps2_data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = ps2_data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (frame_ok(shift_q, parity_q, ps2_data_s)) begin
            scan_valid_d = 1'b1;
            scan_code_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      scan_valid_q <= scan_valid_d;
      scan_code_q  <= scan_code_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scancode decoder
  // ---------------------------------------------------------------------------
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d;
  logic       reset_key_q, reset_key_d;
  logic       cls_key_q, cls_key_d;
  logic [6:0] key_ascii_q, key_ascii_d;
  logic       key_ready_q, key_ready_d;
  logic       make_code;
  logic [6:0] tbl_ascii;
  logic       tbl_valid;

  ps2_scancode_to_ascii u_table (
    .scancode (scan_code_q),
    .shift    (lshift_q | rshift_q),
    .ctrl     (ctrl_q),
    .ext      (ext_q),
    .ascii    (tbl_ascii),
    .valid    (tbl_valid)
  );

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    ctrl_d      = ctrl_q;
    reset_key_d = reset_key_q;
    cls_key_d   = cls_key_q;
    key_ascii_d = key_ascii_q;
    key_ready_d = key_ready_q;
    make_code   = ~brk_q;

    if (key_ack && key_ready_q) key_ready_d = 1'b0;

    if (scan_valid_q) begin
      if (scan_code_q == SC_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code_q == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // E0 12 is a fake shift emitted around PrintScreen; ignore it
        if (!ext_q && scan_code_q == SC_LSHIFT) lshift_d    = make_code;
        if (!ext_q && scan_code_q == SC_RSHIFT) rshift_d    = make_code;
        if (scan_code_q == SC_CTRL)             ctrl_d      = make_code;
        if (!ext_q && scan_code_q == SC_F12)    reset_key_d = make_code;
        if (!ext_q && scan_code_q == SC_F1)     cls_key_d   = make_code;
        // A fresh character beats a simultaneous ack
        if (make_code && tbl_valid) begin
          key_ascii_d = tbl_ascii;
          key_ready_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      ctrl_q      <= 1'b0;
      reset_key_q <= 1'b0;
      cls_key_q   <= 1'b0;
      key_ascii_q <= '0;
      key_ready_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      ctrl_q      <= ctrl_d;
      reset_key_q <= reset_key_d;
      cls_key_q   <= cls_key_d;
      key_ascii_q <= key_ascii_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_ascii = key_ascii_q;
  assign key_ready = key_ready_q;
  assign reset_key = reset_key_q;
  assign cls_key   = cls_key_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FILTER_LEN, default 8: cycles ps2_clk must be stable before the filtered clock changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 14318: idle cycles (1 ms at 14.318 MHz) before an unfinished frame is abandoned.
REQ-003 clk14  input  1  system clock, 14.31818 MHz.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ps2_clk  input  1  PS/2 clock from the user_io keyboard channel; asynchronous to clk14.
REQ-006 ps2_data  input  1  PS/2 data from the user_io keyboard channel; asynchronous to clk14.
REQ-007 key_ascii  output  7  last decoded ASCII character.
REQ-008 key_ready  output  1  character available; feeds the PIA KBD strobe.
REQ-009 key_ack  input  1  PIA KBD data register read; clears key_ready.
REQ-010 reset_key  output  1  high while F12 is held.
REQ-011 cls_key  output  1  high while F1 is held.
REQ-012 frame_err  output  1  one-cycle pulse on each discarded frame.

Function
REQ-013 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer.
REQ-014 Filtered clock SHALL change only after synchronized ps2_clk holds a new level for FILTER_LEN consecutive cycles.
REQ-015 Data SHALL be sampled on the filtered clock's falling edge.
REQ-016 Receiver FSM SHALL use states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE -> DATA SHALL occur on a sampled 0 (start bit); a sampled 1 SHALL leave the FSM in IDLE.
REQ-018 DATA SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-019 PARITY SHALL record the parity bit, then go to STOP.
REQ-020 STOP SHALL return to IDLE in all cases.
REQ-021 A frame SHALL be valid only with odd parity over data+parity and stop bit = 1.
REQ-022 A valid frame SHALL present its scancode to the decoder on the cycle after the stop-bit edge.
REQ-023 An invalid frame SHALL be discarded with frame_err pulsed for 1 cycle.
REQ-024 Outside IDLE, TIMEOUT_CYCLES cycles without a falling edge SHALL force IDLE, discard the partial byte and pulse frame_err.
REQ-025 Decoder: 0xE0 SHALL set the ext flag and 0xF0 SHALL set the brk flag; both flags clear after the next non-prefix byte.
REQ-026 Left shift (0x12) and right shift (0x59) SHALL be tracked as held flags, set on make and cleared on break.
REQ-027 Ctrl (0x14, with or without E0) SHALL be tracked as a held flag, set on make and cleared on break.
REQ-028 F12 (0x07) SHALL drive reset_key: high on make, low on break.
REQ-029 F1 (0x05) SHALL drive cls_key: high on make, low on break.
REQ-030 Mapped make codes SHALL produce ASCII:
 - letters always uppercase 0x41-0x5A;
 - digits 0x30-0x39, or shifted US symbols when shift is held;
 - space 0x29 -> 0x20;
 - Enter 0x5A and E0 5A -> 0x0D;
 - Backspace 0x66 -> 0x5F;
 - Esc 0x76 -> 0x1B;
 - punctuation per US layout, uppercase-only set.
REQ-031 Ctrl+letter SHALL produce letter AND 0x1F.
REQ-032 Break codes, unmapped codes and E0 codes other than 5A/14 SHALL produce no character.
REQ-033 On a produced character: key_ascii SHALL load and key_ready SHALL go 1 on the cycle after scancode presentation (2 cycles after the stop-bit edge).
REQ-034 key_ack while key_ready=1 SHALL clear key_ready on the next cycle.
REQ-035 key_ack while key_ready=0 SHALL have no effect.
REQ-036 A new character arriving while key_ready=1 SHALL overwrite key_ascii; key_ready stays 1 and there is no buffering.
REQ-037 A new character in the same cycle as key_ack SHALL win: key_ascii updated, key_ready stays 1.
REQ-038 Typematic repeats (repeated make codes) SHALL each produce a character.

Reset
REQ-039 rst_n low SHALL immediately clear: key_ascii=0, key_ready=0, reset_key=0, cls_key=0, frame_err=0, FSM=IDLE, bit counter, timeout counter, filter state, ext/brk/shift/ctrl flags.
REQ-040 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.
REQ-041 Synchronizers SHALL reset to 1 (PS/2 idle level).

Structure
REQ-042 Shared package apple1_pkg SHALL hold the scancode constants (SC_EXT, SC_BREAK, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ENTER, SC_F1, SC_F12) and the receiver state enum.
REQ-043 Sub-module ps2_scancode_to_ascii SHALL hold the combinational translation table: inputs scancode, shift, ctrl, ext; outputs ascii[6:0], valid.

Verification
REQ-044 Send 0x1C, then F0 1C -> key_ascii=0x41, key_ready=1 once; no character from the break.
REQ-045 Send 12, 16, F0 16, F0 12 -> key_ascii=0x21 ('!'); a later 16 -> 0x31.
REQ-046 Send 0x1C with a bad parity bit -> frame_err pulses 1 cycle, key_ready stays 0.
REQ-047 Send a start bit + 3 bits, then idle 15000 cycles -> frame_err pulses; a following 0x5A -> key_ascii=0x0D.
REQ-048 key_ready=1 with key_ack asserted in the same cycle a new 0x32 completes -> key_ready stays 1, key_ascii=0x42.
REQ-049 Send 07, then F0 07, with rst_n pulsed low mid-frame -> reset_key 1 then 0; after reset, all outputs 0 and the next frame decodes.
